mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; encodings below are fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 op  in  7  instruction opcode, instr[6:0], from the instruction register.
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7b5  in  1  instr[30].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 imm_src  out  2  immediate format select to the extend stage: 00 I, 01 S, 10 B, 11 J.
REQ-009 pc_write, ir_write, mem_write, reg_write, adr_src  out  1 each  datapath enables and selects.
REQ-010 result_src, alu_src_a, alu_src_b  out  2 each  datapath mux selects.
REQ-011 alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 state  out  4  current state code, for debug.

Function
REQ-013 Multicycle Moore FSM, one state register; state codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10.
REQ-014 Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
REQ-015 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I-ALU), BEQ, JAL, or FETCH for any other opcode.
REQ-016 MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH; EXECUTER, EXECUTEI, JAL->ALUWB.
REQ-017 Unused state codes 11-15 SHALL go to FETCH on the next edge with all write enables 0.
REQ-018 Defaults unless listed: all enables 0, all 2-bit selects 00, adr_src 0, alu_op 00.
REQ-019 FETCH: ir_write 1, alu_src_b 10, result_src 10, pc_update 1.
REQ-020 DECODE: alu_src_a 01, alu_src_b 01.
REQ-021 MEMADR and EXECUTEI: alu_src_a 10, alu_src_b 01; EXECUTEI also alu_op 10.
REQ-022 MEMREAD: adr_src 1; MEMWB: result_src 01, reg_write 1; MEMWRITE: adr_src 1, mem_write 1.
REQ-023 EXECUTER: alu_src_a 10, alu_op 10; ALUWB: reg_write 1.
REQ-024 BEQ: alu_src_a 10, alu_op 01, branch 1.
REQ-025 JAL: alu_src_a 01, alu_src_b 10, pc_update 1.
REQ-026 pc_write = pc_update OR (branch AND zero), combinational on zero.
REQ-027 imm_src decoded combinationally from op in every state: lw and I-ALU 00, sw 01, beq 10, jal 11, all other opcodes 00.
REQ-028 alu_control from alu_op: 00->000; 01->001; 10->by funct3.
REQ-029 funct3 map: 000 gives 001 if op[5] AND funct7b5, else 000; 010->101; 110->011; 111->010; other funct3 values->000.
REQ-030 Cycle counts, FETCH to next FETCH: lw 5, sw 4, R/I-ALU 4, jal 4, beq 3, unsupported opcode 2.

Reset
REQ-031 rst_n low SHALL force state to FETCH immediately, without waiting for a clock edge.
REQ-032 While rst_n is low, pc_write, ir_write, mem_write and reg_write SHALL be 0; all other outputs SHALL show FETCH values.
REQ-033 Reset asserted mid-instruction SHALL abandon that instruction; no further write enable is asserted for it.
REQ-034 The first rising edge after rst_n goes high SHALL perform FETCH.

Verification
REQ-035 lw (op 0000011) from reset -> state sequence 0,1,2,3,4,0; reg_write 1 only in state 4; imm_src 00.
REQ-036 sw -> states 0,1,2,5,0; mem_write 1 only in state 5; imm_src 01; adr_src 1 in state 5.
REQ-037 R-type, funct3 000, funct7b5 1 -> alu_control 001 in state 6; same with op 0010011 -> 000.
REQ-038 beq with zero 1 -> pc_write 1 in state 9; with zero 0 -> pc_write 0; imm_src 10.
REQ-039 jal -> states 0,1,10,8,0; pc_write 1 in states 0 and 10; imm_src 11; op 1111111 -> states 0,1,0.
REQ-040 rst_n pulsed low in MEMWRITE -> state 0 asynchronously, mem_write 0 at once, and no write on release.

Source files
------------

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Main control unit of a multicycle RV32I-subset processor. A single Moore FSM
// steps each instruction through fetch, decode, and its execute and writeback
// states. Datapath selects and enables are decoded from the current state.
//
// Ports
//   clk          sole clock; state advances on the rising edge
//   rst_n        asynchronous active-low reset; forces the FETCH state
//   op           instr[6:0] opcode from the instruction register
//   funct3       instr[14:12]
//   funct7b5     instr[30]; selects sub for R-type funct3 000
//   zero         ALU zero flag, used for beq
//   imm_src      immediate format to extend stage (00 I, 01 S, 10 B, 11 J)
//   pc_write     PC load enable (jump/fetch, or taken branch)
//   ir_write     instruction register load enable
//   mem_write    data memory write enable
//   reg_write    register file write enable
//   adr_src      memory address select (0 PC, 1 ALU result)
//   result_src   result mux select
//   alu_src_a    ALU operand A select
//   alu_src_b    ALU operand B select
//   alu_control  ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   state        current state code, for debug
// -----------------------------------------------------------------------------
module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] imm_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;

  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic [1:0] alu_op;

  // State register; reset forces FETCH without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; any undefined state code returns to FETCH.
  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_R:         nxt_state = S_EXECUTER;
          OP_IALU:      nxt_state = S_EXECUTEI;
          OP_BEQ:       nxt_state = S_BEQ;
          OP_JAL:       nxt_state = S_JAL;
          default:      nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR:   nxt_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt_state = S_MEMWB;
      S_EXECUTER: nxt_state = S_ALUWB;
      S_EXECUTEI: nxt_state = S_ALUWB;
      S_JAL:      nxt_state = S_ALUWB;
      default:    nxt_state = S_FETCH;
    endcase
  end

  // Moore output decode from the current state.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (cur_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  // Write enables are held off while reset is asserted; the state register is
  // already FETCH then, so every other output shows its FETCH value.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_write_raw;
  assign mem_write = rst_n & mem_write_raw;
  assign reg_write = rst_n & reg_write_raw;

  // Immediate format, decoded from the opcode in every state.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // ALU decoder. Subtract for funct3 000 only on R-type (op[5]) with
  // funct7b5 set; an I-type addi with instr[30] set stays an add.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b00: alu_control = 3'b000;
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Directed and randomized instructions are run through mc_controller; every
// cycle the full output set is compared against a reference model built from
// per-opcode state paths and per-state control tables.
// -----------------------------------------------------------------------------
module tb_mc_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] imm_src;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
  } outs_t;

  int n_cmp = 0;
  int n_err = 0;
  int path[$];

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .imm_src(imm_src), .pc_write(pc_write), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Sequence of state codes visited from FETCH up to the next FETCH.
  function automatic void build_path(input logic [6:0] o);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (o)
      7'b0000011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      7'b0100011: begin path.push_back(2); path.push_back(5); end
      7'b0110011: begin path.push_back(6); path.push_back(8); end
      7'b0010011: begin path.push_back(7); path.push_back(8); end
      7'b1100011: path.push_back(9);
      7'b1101111: begin path.push_back(10); path.push_back(8); end
      default: ;
    endcase
  endfunction

  // Expected outputs for a state code, from the per-state control table.
  function automatic outs_t model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input bit in_reset);
    outs_t e;
    logic  pc_upd;
    logic  br;
    int    aop;
    e = '0;
    pc_upd = 1'b0;
    br = 1'b0;
    aop = 0;
    e.state = 4'(st);
    case (st)
      0:  begin e.ir_write = 1'b1; e.alu_src_b = 2'd2; e.result_src = 2'd2; pc_upd = 1'b1; end
      1:  begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; end
      2:  begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
      3:  e.adr_src = 1'b1;
      4:  begin e.result_src = 2'd1; e.reg_write = 1'b1; end
      5:  begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
      6:  begin e.alu_src_a = 2'd2; aop = 2; end
      7:  begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; aop = 2; end
      8:  e.reg_write = 1'b1;
      9:  begin e.alu_src_a = 2'd2; aop = 1; br = 1'b1; end
      10: begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; pc_upd = 1'b1; end
      default: ;
    endcase
    e.pc_write = pc_upd | (br & z);
    if (aop == 1) e.alu_control = 3'b001;
    else if (aop == 2) begin
      if (f3 == 3'b000)      e.alu_control = (o[5] && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) e.alu_control = 3'b101;
      else if (f3 == 3'b110) e.alu_control = 3'b011;
      else if (f3 == 3'b111) e.alu_control = 3'b010;
      else                   e.alu_control = 3'b000;
    end
    if (o == 7'b0100011)      e.imm_src = 2'b01;
    else if (o == 7'b1100011) e.imm_src = 2'b10;
    else if (o == 7'b1101111) e.imm_src = 2'b11;
    else                      e.imm_src = 2'b00;
    if (in_reset) begin
      e.pc_write = 1'b0; e.ir_write = 1'b0; e.mem_write = 1'b0; e.reg_write = 1'b0;
    end
    return e;
  endfunction

  function automatic outs_t sample();
    outs_t a;
    a.state = state; a.pc_write = pc_write; a.ir_write = ir_write;
    a.mem_write = mem_write; a.reg_write = reg_write; a.adr_src = adr_src;
    a.result_src = result_src; a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b;
    a.alu_control = alu_control; a.imm_src = imm_src;
    return a;
  endfunction

  task automatic check(input string tag, input outs_t got, input outs_t exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one instruction starting mid-cycle in FETCH. If abort_at names a
  // path step, reset is pulsed during that step and the instruction dropped.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode, input int abort_at);
    op = o; funct3 = f3; funct7b5 = f7;
    build_path(o);
    for (int i = 0; i < path.size(); i++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      check($sformatf("%s step%0d", name, i), sample(), model(path[i], o, f3, f7, zero, 1'b0));
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check({name, " rst_async"}, sample(), model(0, o, f3, f7, zero, 1'b1));
        @(posedge clk);
        #1 check({name, " rst_hold"}, sample(), model(0, o, f3, f7, zero, 1'b1));
        @(negedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  logic [6:0] ops[7];

  initial begin
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    ops[6] = 7'b1111111;
    rst_n = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    op = 7'b1101111; zero = 1'b1;
    #2 check("reset_async", sample(), model(0, op, funct3, funct7b5, zero, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      op = ops[$urandom_range(0, 6)]; zero = 1'($urandom_range(0, 1));
      #1 check($sformatf("reset_hold%0d", i), sample(), model(0, op, funct3, funct7b5, zero, 1'b1));
    end
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed instructions.
    run_instr("lw",      7'b0000011, 3'b010, 1'b0, 0, -1);
    run_instr("sw",      7'b0100011, 3'b010, 1'b0, 0, -1);
    run_instr("r_sub",   7'b0110011, 3'b000, 1'b1, 0, -1);
    run_instr("i_add",   7'b0010011, 3'b000, 1'b1, 0, -1);
    run_instr("r_slt",   7'b0110011, 3'b010, 1'b0, 0, -1);
    run_instr("r_or",    7'b0110011, 3'b110, 1'b0, 0, -1);
    run_instr("i_and",   7'b0010011, 3'b111, 1'b1, 0, -1);
    run_instr("i_f3_1",  7'b0010011, 3'b001, 1'b0, 0, -1);
    run_instr("beq_t",   7'b1100011, 3'b000, 1'b0, 1, -1);
    run_instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 0, -1);
    run_instr("jal",     7'b1101111, 3'b000, 1'b0, 0, -1);
    run_instr("bad_op",  7'b1111111, 3'b000, 1'b0, 0, -1);
    run_instr("bad_op0", 7'b0000000, 3'b000, 1'b0, 1, -1);

    // Reset pulsed during MEMWRITE, then a clean instruction afterwards.
    run_instr("sw_abort", 7'b0100011, 3'b010, 1'b0, 0, 3);
    run_instr("post_rst", 7'b0100011, 3'b010, 1'b0, 0, -1);

    // Randomized instruction stream.
    for (int k = 0; k < 200; k++) begin
      logic [6:0] ro;
      ro = ($urandom_range(0, 7) == 7) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      run_instr($sformatf("rnd%0d", k), ro, 3'($urandom), 1'($urandom), 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
